// File: rtl/grf_wb_defs.sv
// rtl/grf_wb_defs.sv - shared widths, entry record and constants for the GRF writeback queue
package grf_wb_defs;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int ZERO_REG   = 0;

  // One pending writeback; fields are packed {pc, reg, data}, MSB first
  typedef struct packed {
    logic [DATA_W_DEF-1:0] pc;
    logic [ADDR_W_DEF-1:0] wreg;
    logic [DATA_W_DEF-1:0] data;
  } grf_wb_entry_t;

  localparam int ENTRY_W = $bits(grf_wb_entry_t);

  // Packed entry width for non-default parameterisations
  function automatic int entry_width(input int aw, input int dw);
    return 2 * dw + aw;
  endfunction

endpackage

// File: rtl/grf_wb_store.sv
// rtl/grf_wb_store.sv - circular entry storage with head read-out and youngest-first register lookup
module grf_wb_store
  import grf_wb_defs::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [ADDR_W-1:0] i_reg,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head_pc,
  output logic [ADDR_W-1:0] o_head_reg,
  output logic [DATA_W-1:0] o_head_data,
  input  logic [ADDR_W-1:0] i_lookup_reg,
  output logic              o_lookup_hit,
  output logic [DATA_W-1:0] o_lookup_data
);

  localparam int EW = entry_width(ADDR_W, DATA_W);

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_idx;

  // Pointer advance and entry capture; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= {i_pc, i_reg, i_data};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  assign o_head_pc   = r_mem[r_rd_ptr][EW-1 -: DATA_W];
  assign o_head_reg  = r_mem[r_rd_ptr][DATA_W +: ADDR_W];
  assign o_head_data = r_mem[r_rd_ptr][DATA_W-1:0];

  // Walk occupied slots oldest to youngest so the last match (youngest) wins
  always_comb begin
    o_lookup_hit  = 1'b0;
    o_lookup_data = '0;
    w_idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < i_count) &&
          (i_lookup_reg != ADDR_W'(ZERO_REG)) &&
          (r_mem[w_idx][DATA_W +: ADDR_W] == i_lookup_reg)) begin
        o_lookup_hit  = 1'b1;
        o_lookup_data = r_mem[w_idx][DATA_W-1:0];
      end
    end
  end

endmodule

// File: rtl/grf_wb_queue.sv
// rtl/grf_wb_queue.sv - GRF write-port initiator: handshake, occupancy, output gating; trace under GRF_WB_TRACE_EN
module grf_wb_queue
  import grf_wb_defs::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [DATA_W-1:0]          inPC,
  input  logic [ADDR_W-1:0]          inReg,
  input  logic [DATA_W-1:0]          inData,
  output logic                       writeEnable,
  output logic [DATA_W-1:0]          PCReg,
  output logic [ADDR_W-1:0]          writeReg,
  output logic [DATA_W-1:0]          writeData,
  input  logic [ADDR_W-1:0]          lookupReg,
  output logic                       lookupHit,
  output logic [DATA_W-1:0]          lookupData,
  output logic [$clog2(DEPTH+1)-1:0] pendingCount
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]  r_count;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head_pc;
  logic [ADDR_W-1:0] w_head_reg;
  logic [DATA_W-1:0] w_head_data;

  // Full is judged on registered occupancy, before this cycle's pop
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign inReady = !w_full;

  // Writes to $0 complete the handshake but never occupy a slot
  assign w_push = inValid && inReady && reset && (inReg != ADDR_W'(ZERO_REG));

  // Head retires on every edge it is presented; nothing retires during reset
  assign w_pop = (r_count != '0) && reset;

  // Occupancy tracking; push and pop together leave it unchanged
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  grf_wb_store #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  ($clog2(DEPTH)),
    .CNT_W  (CNT_W)
  ) u_store (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_count       (r_count),
    .i_pc          (inPC),
    .i_reg         (inReg),
    .i_data        (inData),
    .o_head_pc     (w_head_pc),
    .o_head_reg    (w_head_reg),
    .o_head_data   (w_head_data),
    .i_lookup_reg  (lookupReg),
    .o_lookup_hit  (lookupHit),
    .o_lookup_data (lookupData)
  );

  assign writeEnable  = w_pop;
  assign PCReg        = w_pop ? w_head_pc   : '0;
  assign writeReg     = w_pop ? w_head_reg  : '0;
  assign writeData    = w_pop ? w_head_data : '0;
  assign pendingCount = r_count;

`ifdef GRF_WB_TRACE_EN
  // Simulation trace of every committed GRF write
  always @(posedge clk) begin
    if (writeEnable && reset) begin
      $display("@%h: $%d <= %h", PCReg, writeReg, writeData);
    end
  end
`else
`endif

endmodule
